cmp_pipe: RTL
=============

Name: cmp_pipe

Overview:
- Parametrised, pipelined branch/compare unit for the RV32I datapath.
- Evaluates all six branch funct3 conditions on WIDTH-bit operands.
- Carries a tag through an elastic valid/ready pipeline of DEPTH register stages.
- Supports flush on redirect and flags illegal funct3 codes; sits between the execute-stage operand muxes and the branch-resolution/PC-select logic.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- DEPTH, 2, number of register stages between accept and output (1..4).
- TAG_W, 4, width of the opaque tag carried alongside each operation (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers an operation this cycle.
- in_ready  output  1  unit accepts the operation this cycle.
- cmpop  input  3  branch_funct3_t condition code.
- a  input  WIDTH  first operand (rs1).
- b  input  WIDTH  second operand (rs2 or immediate).
- in_tag  input  TAG_W  tag accompanying the operation.
- flush  input  1  discard all in-flight and offered operations.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes the result this cycle.
- out_result  output  1  condition outcome (1 = condition true).
- out_illegal  output  1  cmpop was not a legal branch funct3.
- out_tag  output  TAG_W  tag of the presented result.
- inflight  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits, results, illegal flags and tags go to 0. Outputs read out_valid=0, out_result=0, out_illegal=0, out_tag=0, inflight=0. The reset is released synchronously at clk.
- Conditions are computed combinationally at the input and captured into stage 1:
  - beq: a==b; bne: a!=b.
  - blt: signed a<b; bge: signed a>=b.
  - bltu: unsigned a<b; bgeu: unsigned a>=b.
- Illegal codes (3'b010, 3'b011):
  - result=0 and illegal=1 are captured.
  - The operation still flows and handshakes normally; it is never dropped and never hangs.
- Stages 2..DEPTH delay {valid, result, illegal, tag} unchanged. Stage DEPTH drives the outputs.
- Stage k advances when (stage k+1 is empty) or (stage k+1 advances). The last stage advances when out_ready=1.
  - Ready is computed combinationally back through the stages: in_ready = !stage1.valid | stage1_advances.
  - There is no bubble penalty; throughput is 1 op/cycle when out_ready is held high.
- Latency: an operation accepted at edge N has out_valid=1 after edge N+DEPTH-1 if there are no stalls. Equivalently, it is presented DEPTH cycles after the cycle in_valid&in_ready was asserted.
- Stall (out_ready=0 while out_valid=1):
  - out_result, out_illegal and out_tag are held stable.
  - The pipeline fills. in_ready drops once all DEPTH stages are valid.
- Output data while out_valid=0: out_result, out_illegal and out_tag hold their last values. Benches must not check them.
- Flush (sampled at clk):
  - All valid bits are cleared at that edge.
  - An operation offered in the same cycle is not captured.
  - An out_valid&out_ready handshake in the flush cycle still counts as consumed.
  - in_ready is unaffected by flush.
- inflight = number of stages with valid=1, updated each edge.
  - Simultaneous accept and retire leaves it unchanged.
  - Flush forces it to 0.
- Operands are treated as exactly WIDTH bits. Signed compares use bit WIDTH-1 as the sign. There is no truncation or extension.
- Asserting reset mid-operation discards all in-flight operations immediately, without waiting for a clock edge.

Decomposition:
- rv32i_types (existing package):
  - Reuse branch_funct3_t.
  - Add cmp_stage_t packed struct {valid, result, illegal, tag}. The tag width is fixed by the module parameter, so the struct holds a TAG_W-free header and the tag stays separate.
  - Add a localparam function is_legal_branch(funct3).
- One sub-module is natural: cmp_pipe_stage, a single elastic register slice. It is instantiated DEPTH times via generate, with upstream/downstream valid and advance signals.
- The compare logic stays in cmp_pipe.

Test Plan:
- Reset and latency (DEPTH=2, out_ready=1): release reset, send bltu a=32'h0000_0001, b=32'hFFFF_FFFF, tag=3.
  - Required: out_valid=1 exactly 2 cycles after acceptance, out_result=1, out_tag=3, inflight=1 during transit.
- Signedness: blt with a=32'hFFFF_FFFF (-1), b=32'h0000_0001 -> result 1. bltu with the same operands -> 0. bge with a=b=32'h8000_0000 -> 1. bgeu with a=0, b=1 -> 0.
- Back-pressure: stream 5 ops (tags 0..4) with out_ready=0.
  - Required: in_ready drops after 2 accepts, out_tag=0 is held stable.
  - Then raise out_ready: tags 0..4 emerge in order, one per cycle, none lost or duplicated.
- Illegal op: cmpop=3'b010, a=b=5 -> out_result=0, out_illegal=1, and the handshake completes.
- Flush: with 2 ops in flight plus in_valid=1, assert flush for 1 cycle.
  - Required: next cycle inflight=0, out_valid=0, and the offered op never appears.
  - A subsequent beq a=b=7 -> result 1.
- Async reset mid-stream: drop rst between clock edges with a full pipe.
  - Required: out_valid=0 and inflight=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: branch condition codes and the compare-pipe
// stage header. The tag is kept out of the header so its width can follow
// the instantiating module's parameter.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    logic valid;
    logic result;
    logic illegal;
  } cmp_stage_t;

  // 3'b010 and 3'b011 are the only funct3 codes with no branch meaning.
  function automatic logic is_legal_branch(logic [2:0] funct3);
    return !((funct3 == 3'b010) || (funct3 == 3'b011));
  endfunction

endpackage

// File: rtl/cmp_pipe_stage.sv
// One elastic register slice of the compare pipe.
// Ports: clk/rst (async active-low), flush, upstream header/tag in with
// up_rdy out, downstream dn_rdy in, registered header/tag out.
// Latency 1 cycle; loads whenever empty or when downstream takes our entry,
// so a full pipe still moves one op per cycle.
module cmp_pipe_stage
  import rv32i_types::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  cmp_stage_t       up_hdr,
  input  logic [TAG_W-1:0] up_tag,
  output logic             up_rdy,
  input  logic             dn_rdy,
  output cmp_stage_t       hdr,
  output logic [TAG_W-1:0] tag
);

  cmp_stage_t       hdr_q, hdr_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Combinational ready chain: a slot frees up the same cycle it drains.
  assign up_rdy = !hdr_q.valid || dn_rdy;

  always_comb begin
    hdr_d = hdr_q;
    tag_d = tag_q;
    if (up_rdy) begin
      hdr_d.valid = up_hdr.valid;
      // Payload only changes on a real capture, so outputs hold their last
      // values across bubbles.
      if (up_hdr.valid && !flush) begin
        hdr_d.result  = up_hdr.result;
        hdr_d.illegal = up_hdr.illegal;
        tag_d         = up_tag;
      end
    end
    if (flush) begin
      hdr_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q <= '0;
      tag_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      tag_q <= tag_d;
    end
  end

  assign hdr = hdr_q;
  assign tag = tag_q;

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined RV32I branch-compare unit: evaluates the branch condition on
// a/b at the input and carries {result, illegal, tag} through DEPTH elastic
// stages. Ports: in_valid/in_ready/cmpop/a/b/in_tag upstream, out_valid/
// out_ready/out_result/out_illegal/out_tag downstream, flush, inflight count.
// Latency DEPTH edges from accept; stalls fill the pipe, then drop in_ready.
module cmp_pipe
  import rv32i_types::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 cmpop,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_result,
  output logic                       out_illegal,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic res_c;
  logic ill_c;
  logic slt_c;
  logic ult_c;

  // Index 0 is the combinational input; index DEPTH drives the outputs.
  cmp_stage_t       st_hdr [DEPTH+1];
  logic [TAG_W-1:0] st_tag [DEPTH+1];
  logic             st_rdy [DEPTH+1];

  assign slt_c = $signed(a) < $signed(b);
  assign ult_c = a < b;
  assign ill_c = !is_legal_branch(cmpop);

  always_comb begin
    res_c = 1'b0;
    case (branch_funct3_t'(cmpop))
      F3_BEQ:  res_c = (a == b);
      F3_BNE:  res_c = (a != b);
      F3_BLT:  res_c = slt_c;
      F3_BGE:  res_c = !slt_c;
      F3_BLTU: res_c = ult_c;
      F3_BGEU: res_c = !ult_c;
      default: res_c = 1'b0;
    endcase
  end

  assign st_hdr[0]     = '{valid: in_valid, result: res_c, illegal: ill_c};
  assign st_tag[0]     = in_tag;
  assign st_rdy[DEPTH] = out_ready;
  assign in_ready      = st_rdy[0];

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    cmp_pipe_stage #(.TAG_W(TAG_W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .up_hdr (st_hdr[k-1]),
      .up_tag (st_tag[k-1]),
      .up_rdy (st_rdy[k-1]),
      .dn_rdy (st_rdy[k]),
      .hdr    (st_hdr[k]),
      .tag    (st_tag[k])
    );
  end

  assign out_valid   = st_hdr[DEPTH].valid;
  assign out_result  = st_hdr[DEPTH].result;
  assign out_illegal = st_hdr[DEPTH].illegal;
  assign out_tag     = st_tag[DEPTH];

  // Derived from the stage valid bits, so it follows reset and flush for free.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      inflight = inflight + CNT_W'(st_hdr[k].valid);
    end
  end

endmodule
